// File: rtl/sram_word_arbiter.sv
// sram_word_arbiter: arbitrates 32-bit word requests from the Fetch and
// Memory stages and splits each into two 16-bit half-word cycles on an
// external asynchronous SRAM. Memory stage wins ties. Ready pulses for
// one cycle in DONE; read words are held in per-port result registers.
module sram_word_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       data,
  output logic              wre
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI, S_RD_LO, S_WR_HI_S, S_WR_HI_P, S_WR_LO_S, S_WR_LO_P, S_DONE
  } state_t;

  // Read holds last 1+RD_WAIT cycles; the counter runs 0..RD_WAIT.
  localparam logic [1:0] LP_WAIT = 2'(RD_WAIT);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-2:0]   r_word_addr;   // word address, bit 0 supplied per half
  logic                r_rw;
  logic [31:0]         r_wdata;
  logic                r_sel_mem;     // 1 = Memory stage owns the access
  logic [1:0]          r_wait;
  logic [15:0]         r_rd_hi;
  logic [31:0]         r_if_rdata;
  logic [31:0]         r_mem_rdata;
  logic                w_hold_done;
  logic                w_drive;
  logic [15:0]         w_wr_half;
  logic                w_unused_bits;

  // Bit 0 of the request addresses is a don't-care: halves are chosen by state.
  assign w_unused_bits = if_addr[0] ^ mem_addr[0];

  assign w_hold_done = (r_wait == LP_WAIT);

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: Memory stage has priority in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req)     w_next = mem_rw ? S_WR_HI_S : S_RD_HI;
        else if (if_req) w_next = S_RD_HI;
      end
      S_RD_HI:   if (w_hold_done) w_next = S_RD_LO;
      S_RD_LO:   if (w_hold_done) w_next = S_DONE;
      S_WR_HI_S: w_next = S_WR_HI_P;
      S_WR_HI_P: w_next = S_WR_LO_S;
      S_WR_LO_S: w_next = S_WR_LO_P;
      S_WR_LO_P: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Latch the winning request in IDLE so later input changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_addr <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_sel_mem   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (mem_req) begin
        r_word_addr <= mem_addr[ADDR_W-1:1];
        r_rw        <= mem_rw;
        r_wdata     <= mem_wdata;
        r_sel_mem   <= 1'b1;
      end else if (if_req) begin
        r_word_addr <= if_addr[ADDR_W-1:1];
        r_rw        <= 1'b0;
        r_sel_mem   <= 1'b0;
      end
    end
  end

  // Read hold counter: restarts for each half-word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if ((r_state == S_RD_HI) || (r_state == S_RD_LO)) begin
      if (w_hold_done) r_wait <= '0;
      else             r_wait <= r_wait + 2'd1;
    end else begin
      r_wait <= '0;
    end
  end

  // Capture read halves on the last hold cycle; assemble into the owner's register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_hi     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else if (w_hold_done) begin
      if (r_state == S_RD_HI) begin
        r_rd_hi <= data;
      end else if (r_state == S_RD_LO) begin
        if (r_sel_mem) r_mem_rdata <= {r_rd_hi, data};
        else           r_if_rdata  <= {r_rd_hi, data};
      end
    end
  end

  // SRAM pin decode: address, write enable and data drive follow state only,
  // so an asynchronous reset releases the bus immediately.
  always_comb begin
    addr      = '0;
    wre       = 1'b1;
    w_drive   = 1'b0;
    w_wr_half = '0;
    case (r_state)
      S_RD_HI: addr = {r_word_addr, 1'b0};
      S_RD_LO: addr = {r_word_addr, 1'b1};
      S_WR_HI_S, S_WR_HI_P: begin
        addr      = {r_word_addr, 1'b0};
        w_drive   = 1'b1;
        w_wr_half = r_wdata[31:16];
        wre       = (r_state != S_WR_HI_P);
      end
      S_WR_LO_S, S_WR_LO_P: begin
        addr      = {r_word_addr, 1'b1};
        w_drive   = 1'b1;
        w_wr_half = r_wdata[15:0];
        wre       = (r_state != S_WR_LO_P);
      end
      default: ;
    endcase
  end

  assign data      = w_drive ? w_wr_half : 16'bz;
  assign if_ready  = (r_state == S_DONE) && !r_sel_mem;
  assign mem_ready = (r_state == S_DONE) &&  r_sel_mem;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: doc/sram_word_arbiter.md
Name: sram_word_arbiter

Overview:
- Sits between the Fetch and Memory stages and the external 16-bit asynchronous SRAM pins of the Mips top level.
- Arbitrates 32-bit word requests from the two stages and splits each into two sequential 16-bit half-word RAM cycles.
- Returns assembled read data, or confirms completed writes, with a one-cycle ready pulse.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- RD_WAIT, 0, extra wait cycles added to each read half-word access (0..3).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch read request; held high until if_ready.
- if_addr  input  ADDR_W  fetch half-word address; bit 0 is ignored.
- if_ready  output  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  output  32  fetched word.
- mem_req  input  1  data request; held high until mem_ready.
- mem_rw  input  1  1 = write, 0 = read.
- mem_addr  input  ADDR_W  data half-word address; bit 0 is ignored.
- mem_wdata  input  32  write word.
- mem_ready  output  1  one-cycle pulse: read data valid, or write complete.
- mem_rdata  output  32  read word.
- addr  output  ADDR_W  SRAM address.
- data  inout  16  SRAM data bus; driven only during write phases, otherwise high-Z.
- wre  output  1  SRAM write enable, active-low.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - addr=0, wre=1, data=high-Z.
  - if_ready=0, mem_ready=0; if_rdata and mem_rdata cleared to 0.
- Word layout (big-endian): high half at {a[ADDR_W-1:1],0}, low half at {a[ADDR_W-1:1],1}.
- FSM states: IDLE, RD_HI, RD_LO, WR_HI_S, WR_HI_P, WR_LO_S, WR_LO_P, DONE.
- IDLE:
  - Samples requests.
  - mem_req has priority over if_req whenever both are high in the same cycle.
  - The winner's address, rw and wdata are latched into internal registers; later input changes are ignored until DONE.
  - Read goes to RD_HI; write goes to WR_HI_S.
- Read path:
  - RD_HI: addr = even address, wre=1. Held for 1+RD_WAIT cycles; data is captured into result[31:16] on the final cycle's edge.
  - RD_LO: same, with the odd address, capturing result[15:0].
  - Then DONE.
- Write path:
  - WR_HI_S (setup): addr = even address, data = wdata[31:16], wre=1, one cycle.
  - WR_HI_P (pulse): same addr and data, wre=0, one cycle.
  - WR_LO_S / WR_LO_P: same pattern with the odd address and wdata[15:0].
  - Then DONE.
  - data is driven only in the four write states. wre is low only in the two P states.
- DONE:
  - Exactly one cycle. The winning port's ready pulses high.
  - For a read, the port's rdata register holds the assembled word from this cycle until that port's next completed read.
  - Next state is IDLE.
- Latency:
  - Read with RD_WAIT=0: request sampled in IDLE at cycle N, ready at cycle N+3.
  - Write: ready at cycle N+5.
- Back-to-back requests:
  - A request still high in the IDLE cycle after DONE is treated as a new access.
  - Requesters must drop req in the cycle after ready unless they intend another access.
- A losing request stays pending with no side effects; it is served on a later IDLE cycle in which mem_req is low.
- No fairness is required: the Memory stage cannot issue continuous requests.
- Reset mid-operation:
  - The access is aborted, the bus is released immediately and wre returns high.
  - No ready pulse is issued for the aborted request. A partial write may leave the high half written.
- mem_rw=1 with if_req: not applicable; the fetch port is read-only.

Test Plan:
- Reset mid-write: assert reset during WR_HI_P -> wre=1 and data=Z asynchronously, same cycle; no mem_ready afterwards; after release, IDLE accepts a new request.
- Fetch read: SRAM model holds 0x1234 at 0x00100 and 0xABCD at 0x00101; if_req with if_addr=0x00101 (bit 0 ignored) -> addr shows 0x00100 then 0x00101; if_ready at N+3; if_rdata=0x1234ABCD.
- Data write: mem_rw=1, mem_addr=0x3FFFE, mem_wdata=0xDEADBEEF -> wre low exactly two cycles; data=0xDEAD at 0x3FFFE, then 0xBEEF at 0x3FFFF; mem_ready at N+5; read-back gives 0xDEADBEEF.
- Simultaneous requests: if_req and mem_req (read, 0x00200) rise together -> mem served first and mem_ready at N+3; fetch begins in the following IDLE; if_ready at N+7; no overlap of addr phases.
- RD_WAIT=2: fetch read -> each half-word address held 3 cycles; if_ready at N+7; data sampled on the last cycle of each hold.
- Bus discipline: during any read sequence, data is never driven by the block (a contention checker stays silent); wre never goes low outside the P states.
